// File: rtl/dcache_fill_if.sv
// Signal bundle between the D-cache miss controller, the MEM stage and main memory.
// The master side is the fill controller; the slave side is its environment.
interface dcache_fill_if #(
    parameter int MISS_CNT_W = 16
);
    logic                  miss_detected;
    logic [15:0]           miss_address;
    logic                  victim_way;
    logic                  mem_data_valid;
    logic                  fsm_busy;
    logic                  mem_rd_en;
    logic [15:0]           mem_address;
    logic                  write_data_array;
    logic                  write_tag_array;
    logic [15:0]           cache_word_addr;
    logic                  fill_way;
    logic [MISS_CNT_W-1:0] miss_count;

    modport master (
        input  miss_detected, miss_address, victim_way, mem_data_valid,
        output fsm_busy, mem_rd_en, mem_address, write_data_array,
        output write_tag_array, cache_word_addr, fill_way, miss_count
    );

    modport slave (
        output miss_detected, miss_address, victim_way, mem_data_valid,
        input  fsm_busy, mem_rd_en, mem_address, write_data_array,
        input  write_tag_array, cache_word_addr, fill_way, miss_count
    );
endinterface

// File: rtl/dcache_fill_ctrl.sv
// D-cache miss handler: stalls the pipeline, streams one block of word reads from
// main memory, steers returned words into the victim way and writes the tag at the end.
module dcache_fill_ctrl #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MISS_CNT_W      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    dcache_fill_if.master bus
);
    typedef enum logic {IDLE, FILL} state_t;

    state_t                state_q, state_d;
    logic [15:0]           base_q;
    logic [3:0]            issue_cnt_q;
    logic [3:0]            ret_cnt_q;
    logic                  fill_way_q;
    logic                  rd_en_q;
    logic [15:0]           mem_addr_q;
    logic [MISS_CNT_W-1:0] miss_cnt_q;
    logic                  busy;
    logic                  wr_data;
    logic                  wr_tag;

    function automatic logic [MISS_CNT_W-1:0] sat_inc(input logic [MISS_CNT_W-1:0] v);
        return (&v) ? v : v + MISS_CNT_W'(1);
    endfunction

    // Word offsets never carry into bit 4, so OR-ing into the aligned base is exact.
    function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [3:0] idx);
        return base | {12'b0, idx[2:0], 1'b0};
    endfunction

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        wr_data = 1'b0;
        wr_tag  = 1'b0;
        case (state_q)
            IDLE: begin
                busy = bus.miss_detected;
                if (bus.miss_detected) state_d = FILL;
            end
            FILL: begin
                busy = 1'b1;
                if (bus.mem_data_valid) begin
                    wr_data = 1'b1;
                    if (ret_cnt_q == 4'(WORDS_PER_BLOCK - 1)) begin
                        wr_tag  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // issue_cnt_q counts requests already placed on the registered request port,
    // so the first request leaves in the cycle right after detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            fill_way_q  <= 1'b0;
            rd_en_q     <= 1'b0;
            mem_addr_q  <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.miss_detected) begin
                        base_q      <= bus.miss_address & 16'hFFF0;
                        fill_way_q  <= bus.victim_way;
                        issue_cnt_q <= 4'd1;
                        ret_cnt_q   <= 4'd0;
                        rd_en_q     <= 1'b1;
                        mem_addr_q  <= bus.miss_address & 16'hFFF0;
                        miss_cnt_q  <= sat_inc(miss_cnt_q);
                    end
                end
                FILL: begin
                    if (issue_cnt_q < 4'(WORDS_PER_BLOCK)) begin
                        rd_en_q     <= 1'b1;
                        mem_addr_q  <= word_addr(base_q, issue_cnt_q);
                        issue_cnt_q <= issue_cnt_q + 4'd1;
                    end else begin
                        rd_en_q <= 1'b0;
                    end
                    if (bus.mem_data_valid) ret_cnt_q <= ret_cnt_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.fsm_busy         = busy;
    assign bus.mem_rd_en        = rd_en_q;
    assign bus.mem_address      = mem_addr_q;
    assign bus.write_data_array = wr_data;
    assign bus.write_tag_array  = wr_tag;
    assign bus.cache_word_addr  = word_addr(base_q, ret_cnt_q);
    assign bus.fill_way         = fill_way_q;
    assign bus.miss_count       = miss_cnt_q;
endmodule

// File: tb/tb_dcache_fill_ctrl.sv
// Randomized bench for dcache_fill_ctrl against a cycle-timeline model of a block fill.
// A second instance with a 3-bit miss counter exposes counter saturation in a short run.
module tb_dcache_fill_ctrl;
    localparam int MEM_LATENCY = 4;
    localparam int SAT_W       = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_fill_if #(.MISS_CNT_W(16))    bus ();
    dcache_fill_if #(.MISS_CNT_W(SAT_W)) bus_s ();

    dcache_fill_ctrl #(.WORDS_PER_BLOCK(8), .MISS_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master));
    dcache_fill_ctrl #(.WORDS_PER_BLOCK(8), .MISS_CNT_W(SAT_W)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s.master));

    // Stimulus variables
    logic        miss_det, vway, noise;
    logic [15:0] miss_addr;
    logic [MEM_LATENCY-1:0] mem_pipe;

    // Reference model: position inside the 13-cycle fill timeline
    bit          m_active;
    int          m_k;
    logic [15:0] m_base;
    logic        m_way;
    int          fills;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        logic dv;
        dv = mem_pipe[MEM_LATENCY-1] | (noise & ~m_active);
        bus.miss_detected    = miss_det;  bus_s.miss_detected  = miss_det;
        bus.miss_address     = miss_addr; bus_s.miss_address   = miss_addr;
        bus.victim_way       = vway;      bus_s.victim_way     = vway;
        bus.mem_data_valid   = dv;        bus_s.mem_data_valid = dv;
    endtask

    function automatic int sat_max(input int w);
        return (1 << w) - 1;
    endfunction

    // One clock cycle: apply inputs, check outputs at the falling edge, advance the model.
    task automatic run_cycle();
        logic rd_seen;
        logic exp_busy, exp_rd, exp_wr, exp_tag;
        logic [15:0] exp_ra, exp_wa;
        int exp_cnt, exp_cnt_s;
        drive();
        @(negedge clk);
        exp_busy  = m_active | miss_det;
        exp_rd    = m_active && (m_k <= 8);
        exp_wr    = m_active && (m_k >= 5);
        exp_tag   = m_active && (m_k == 12);
        exp_ra    = m_base + 16'(2 * (m_k - 1));
        exp_wa    = m_base + 16'(2 * (m_k - 5));
        exp_cnt   = (fills > sat_max(16)) ? sat_max(16) : fills;
        exp_cnt_s = (fills > sat_max(SAT_W)) ? sat_max(SAT_W) : fills;
        check_val("busy",     32'(bus.fsm_busy),         32'(exp_busy));
        check_val("rd_en",    32'(bus.mem_rd_en),        32'(exp_rd));
        if (exp_rd) check_val("rd_addr", 32'(bus.mem_address), 32'(exp_ra));
        check_val("wr_data",  32'(bus.write_data_array), 32'(exp_wr));
        if (exp_wr) check_val("wr_addr", 32'(bus.cache_word_addr), 32'(exp_wa));
        check_val("wr_tag",   32'(bus.write_tag_array),  32'(exp_tag));
        check_val("fill_way", 32'(bus.fill_way),         32'(m_way));
        check_val("miss_cnt", 32'(bus.miss_count),       32'(exp_cnt));
        check_val("miss_cnt_sat", 32'(bus_s.miss_count), 32'(exp_cnt_s));
        if (m_active) begin
            if (m_k == 12) m_active = 1'b0;
            else           m_k++;
        end else if (miss_det) begin
            m_active = 1'b1;
            m_k      = 1;
            m_base   = miss_addr & 16'hFFF0;
            m_way    = vway;
            fills++;
        end
        rd_seen = bus.mem_rd_en;
        @(posedge clk);
        #1;
        mem_pipe = {mem_pipe[MEM_LATENCY-2:0], rd_seen};
    endtask

    // Asynchronous reset asserted mid-cycle; called right after a rising edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        miss_det = 1'b0; noise = 1'b0; mem_pipe = '0;
        drive();
        #1;
        check_val("rst_busy",  32'(bus.fsm_busy),         32'd0);
        check_val("rst_rd",    32'(bus.mem_rd_en),        32'd0);
        check_val("rst_wr",    32'(bus.write_data_array), 32'd0);
        check_val("rst_tag",   32'(bus.write_tag_array),  32'd0);
        check_val("rst_way",   32'(bus.fill_way),         32'd0);
        check_val("rst_cnt",   32'(bus.miss_count),       32'd0);
        check_val("rst_cnt_s", 32'(bus_s.miss_count),     32'd0);
        check_val("rst_raddr", 32'(bus.mem_address),      32'd0);
        check_val("rst_waddr", 32'(bus.cache_word_addr),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_active = 1'b0; m_k = 0; m_base = '0; m_way = 1'b0; fills = 0;
    endtask

    task automatic start_miss(input logic [15:0] addr, input logic way);
        miss_det = 1'b1; miss_addr = addr; vway = way; noise = 1'b0;
        run_cycle();
        miss_det = 1'b0;
    endtask

    task automatic idle_noise(input int n);
        miss_det = 1'b0;
        repeat (n) begin
            noise = 1'($urandom);
            run_cycle();
        end
        noise = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; miss_det = 1'b0; miss_addr = '0; vway = 1'b0; noise = 1'b0;
        mem_pipe = '0; m_active = 1'b0; m_k = 0; m_base = '0; m_way = 1'b0; fills = 0;
        drive();
        @(posedge clk);
        #1;
        do_reset();
        idle_noise(6);

        // Single miss; request-side inputs move while the fill is in progress
        start_miss(16'h1236, 1'b1);
        miss_addr = 16'hFFFE; vway = 1'b0;
        repeat (12) run_cycle();

        // Second miss in the very cycle the stall drops
        start_miss(16'hABC0, 1'b1);
        repeat (12) run_cycle();
        idle_noise(4);

        // Reset after the third word has been written
        start_miss(16'h2468, 1'b1);
        repeat (7) run_cycle();
        do_reset();
        idle_noise(3);
        start_miss(16'h3456, 1'b0);
        repeat (12) run_cycle();
        idle_noise(2);

        // Random fills with random gaps (gap 0 gives back-to-back) and ignored inputs during FILL
        repeat (40) begin
            idle_noise($urandom_range(0, 3));
            start_miss(16'($urandom), 1'($urandom));
            repeat (12) begin
                miss_det  = 1'($urandom);
                miss_addr = 16'($urandom);
                vway      = 1'($urandom);
                noise     = 1'($urandom);
                run_cycle();
            end
            miss_det = 1'b0;
        end
        idle_noise(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/dcache_fill_ctrl.md
Name: dcache_fill_ctrl

Overview:
Miss-handling controller for the 2-way set-associative data cache in the MEM stage. It detects a D-cache miss, stalls the pipeline and issues 8 pipelined word reads to multi-cycle main memory. It steers the returned words into the victim way and writes the tag once the block is complete. It holds the MEM/WB pipeline register contents stable (via stall) until the fill completes.

Parameters:
MEM_LATENCY, 4, cycles from a read request to its mem_data_valid; the bench memory model honours this.
WORDS_PER_BLOCK, 8, 16-bit words per cache block; fixed at 8 (16-byte block).
MISS_CNT_W, 16, width of the saturating miss counter.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
miss_detected  input  1  MEM stage has a D-cache access that missed (MemEnable & ~DCACHE_hit).
miss_address  input  16  byte address of the missing access.
victim_way  input  1  way to replace (from the set's LRU bit); 0 = first way, 1 = second way.
mem_data_valid  input  1  main memory returns one word this cycle.
fsm_busy  output  1  stall request to PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
mem_rd_en  output  1  read request to main memory this cycle.
mem_address  output  16  byte address of the current read request.
write_data_array  output  1  write the returned word into the cache data array.
write_tag_array  output  1  write tag and valid bit for the filled block.
cache_word_addr  output  16  byte address of the word being written into the data array.
fill_way  output  1  latched victim way for the whole fill.
miss_count  output  MISS_CNT_W  number of fills started since reset; saturates at all-ones.

Behaviour:
- Reset is asynchronous and active-low: rst_n low forces state IDLE. All outputs and counters go to 0, including miss_count and fill_way.
- Two states: IDLE and FILL.
- IDLE:
  - fsm_busy = miss_detected, combinational, so the stall is raised in the detection cycle.
  - mem_rd_en, write_data_array and write_tag_array are 0.
  - On miss_detected: latch base = {miss_address[15:4], 4'b0000} and fill_way = victim_way; clear issue_cnt and ret_cnt; increment miss_count (saturating); go to FILL.
- FILL:
  - fsm_busy = 1.
  - Issue: while issue_cnt < 8, mem_rd_en = 1 and mem_address = base + 2*issue_cnt; issue_cnt increments each cycle. One request per cycle, so exactly 8 requests in the first 8 FILL cycles.
  - Return: when mem_data_valid = 1, write_data_array = 1 and cache_word_addr = base + 2*ret_cnt; ret_cnt then increments.
  - On the cycle the 8th word returns (ret_cnt = 7 and mem_data_valid = 1), write_tag_array = 1 in the same cycle and the next state is IDLE.
- Timing with MEM_LATENCY = 4 and detection in cycle t:
  - requests issued in t+1..t+8;
  - data written in t+5..t+12;
  - tag written in t+12;
  - fsm_busy high for t..t+12 and low from t+13 (unless a new miss arrives).
- Latched values are used throughout FILL; miss_detected, miss_address and victim_way are ignored while in FILL.
- mem_data_valid is ignored in IDLE; no write strobes are generated.
- Outside active cycles, mem_address and cache_word_addr hold base + offset of the last value driven; they are don't-care when their strobes are low.
- Counters are 4 bits wide, so issue_cnt can reach 8 without wrapping. Address arithmetic stays within the 16-byte block: no carry into bit 4.
- Back-to-back misses: a miss_detected present in the cycle after returning to IDLE starts a new fill immediately.
- Reset mid-fill: the FSM aborts to IDLE and write_tag_array is never pulsed, so the partial block stays invalid.
- All state and outputs are registered, except fsm_busy in IDLE and the return-path strobes, which are decoded from state and mem_data_valid.

Test Plan:
- Reset: rst_n low for 2 cycles, including mid-cycle assertion -> all outputs 0, state IDLE, miss_count = 0.
- Single miss: miss_address = 0x1236, victim_way = 1, MEM_LATENCY = 4 -> mem_rd_en in 8 consecutive cycles with addresses 0x1230..0x123E step 2. write_data_array in 8 cycles with cache_word_addr 0x1230..0x123E. write_tag_array on the 8th write. fill_way = 1. fsm_busy high for 13 cycles. miss_count = 1.
- Inputs change during FILL: toggle miss_address to 0xFFFE and victim_way to 0 while busy -> addresses and fill_way unchanged from the latched values.
- Back-to-back misses: second miss at 0xABC0 asserted the cycle fsm_busy drops -> new fill starts immediately. Requests run 0xABC0..0xABCE. miss_count = 2.
- Reset mid-fill: rst_n low after the 3rd returned word -> no write_tag_array pulse, busy = 0. A following miss performs a full fill with correct addresses.
- Saturation and idle noise: preload 0xFFFE misses, then run 3 more -> miss_count = 0xFFFF. mem_data_valid pulses in IDLE produce no write strobes.
